// File: rtl/branch_update_queue_pkg.sv
// Shared types and sizing for the branch update queue: entry states, entry record layout
// and the redirect-target helper used at mispredict retire.
package branch_update_queue_pkg;

  localparam int DEPTH     = 8;
  localparam int PC_W      = 32;
  localparam int PHT_IDX_W = 7;
  localparam int BHT_IDX_W = 4;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_INVALID  = 2'd0,
    ST_PENDING  = 2'd1,
    ST_RESOLVED = 2'd2
  } entry_state_e;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [PHT_IDX_W-1:0] pht_index;
    logic [BHT_IDX_W-1:0] bht_index;
    logic                 pred_taken;
    logic [PC_W-1:0]      pred_target;
    logic                 act_taken;
    logic [PC_W-1:0]      act_target;
    logic                 mispred;
  } bq_entry_t;

  // Correct fetch address once the real outcome is known; fall-through wraps mod 2^PC_W.
  function automatic logic [PC_W-1:0] redirect_target(input logic act_taken,
                                                      input logic [PC_W-1:0] act_target,
                                                      input logic [PC_W-1:0] pc);
    return act_taken ? act_target : pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Fetch/execute/retire-facing bus of the branch update queue.
// BRANCH_UPDATE_STATS_EN adds the retire/mispredict statistic counters.
interface branch_update_queue_if;
  import branch_update_queue_pkg::*;

  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [PC_W-1:0]      alloc_pc;
  logic [PHT_IDX_W-1:0] alloc_pht_index;
  logic [BHT_IDX_W-1:0] alloc_bht_index;
  logic                 alloc_pred_taken;
  logic [PC_W-1:0]      alloc_pred_target;
  logic [PTR_W-1:0]     alloc_tag;
  logic                 resolve_valid;
  logic [PTR_W-1:0]     resolve_tag;
  logic                 resolve_taken;
  logic [PC_W-1:0]      resolve_target;
  logic                 retire_valid;
  logic                 update_en;
  logic [PHT_IDX_W-1:0] update_PHT_index;
  logic [BHT_IDX_W-1:0] update_BHT_index;
  logic                 branch_en;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0]          stat_retired;
  logic [31:0]          stat_mispred;
`endif

  modport master (
    output alloc_valid, alloc_pc, alloc_pht_index, alloc_bht_index, alloc_pred_taken,
           alloc_pred_target, resolve_valid, resolve_tag, resolve_taken, resolve_target,
           retire_valid,
    input  alloc_ready, alloc_tag, update_en, update_PHT_index, update_BHT_index, branch_en,
           redirect_valid, redirect_pc
`ifdef BRANCH_UPDATE_STATS_EN
    , input stat_retired, stat_mispred
`endif
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pht_index, alloc_bht_index, alloc_pred_taken,
           alloc_pred_target, resolve_valid, resolve_tag, resolve_taken, resolve_target,
           retire_valid,
    output alloc_ready, alloc_tag, update_en, update_PHT_index, update_BHT_index, branch_en,
           redirect_valid, redirect_pc
`ifdef BRANCH_UPDATE_STATS_EN
    , output stat_retired, stat_mispred
`endif
  );

endinterface

// File: rtl/branch_update_queue.sv
// In-order branch queue: out-of-order resolve by tag, in-order retire into the predictor
// update port, redirect + full squash on mispredict. BRANCH_UPDATE_STATS_EN adds stat counters.
module branch_update_queue
  import branch_update_queue_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  branch_update_queue_if.slave bus
);

  entry_state_e         state_q [DEPTH];
  entry_state_e         state_d [DEPTH];
  bq_entry_t            entry_q [DEPTH];
  bq_entry_t            entry_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 update_en_q, update_en_d;
  logic [PHT_IDX_W-1:0] update_pht_q, update_pht_d;
  logic [BHT_IDX_W-1:0] update_bht_q, update_bht_d;
  logic                 branch_en_q, branch_en_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]      redirect_pc_q, redirect_pc_d;
`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0]          stat_retired_q, stat_retired_d;
  logic [31:0]          stat_mispred_q, stat_mispred_d;
`endif

  logic alloc_ready, alloc_fire, resolve_hit, retire_fire, squash;

  // Retire looks only at the registered head state, so a same-cycle resolve cannot retire.
  assign alloc_ready = count_q < CNT_W'(DEPTH);
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign resolve_hit = bus.resolve_valid && (state_q[bus.resolve_tag] == ST_PENDING);
  assign retire_fire = bus.retire_valid && (state_q[head_q] == ST_RESOLVED);
  assign squash      = retire_fire && entry_q[head_q].mispred;

  always_comb begin
    state_d          = state_q;
    entry_d          = entry_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    update_en_d      = retire_fire;
    update_pht_d     = update_pht_q;
    update_bht_d     = update_bht_q;
    branch_en_d      = 1'b0;
    redirect_valid_d = squash;
    redirect_pc_d    = redirect_pc_q;

    if (resolve_hit) begin
      state_d[bus.resolve_tag]            = ST_RESOLVED;
      entry_d[bus.resolve_tag].act_taken  = bus.resolve_taken;
      entry_d[bus.resolve_tag].act_target = bus.resolve_target;
      entry_d[bus.resolve_tag].mispred    =
        (bus.resolve_taken != entry_q[bus.resolve_tag].pred_taken) ||
        (bus.resolve_taken && (bus.resolve_target != entry_q[bus.resolve_tag].pred_target));
    end

    if (retire_fire) begin
      update_pht_d = entry_q[head_q].pht_index;
      update_bht_d = entry_q[head_q].bht_index;
      branch_en_d  = entry_q[head_q].act_taken;
    end

    // A mispredict wipes every entry, including one allocated this same cycle.
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ST_INVALID;
      head_d        = tail_q;
      count_d       = '0;
      redirect_pc_d = redirect_target(entry_q[head_q].act_taken, entry_q[head_q].act_target,
                                      entry_q[head_q].pc);
    end else begin
      if (retire_fire) begin
        state_d[head_q] = ST_INVALID;
        head_d          = head_q + PTR_W'(1);
      end
      if (alloc_fire) begin
        state_d[tail_q]             = ST_PENDING;
        entry_d[tail_q].pc          = bus.alloc_pc;
        entry_d[tail_q].pht_index   = bus.alloc_pht_index;
        entry_d[tail_q].bht_index   = bus.alloc_bht_index;
        entry_d[tail_q].pred_taken  = bus.alloc_pred_taken;
        entry_d[tail_q].pred_target = bus.alloc_pred_target;
        entry_d[tail_q].act_taken   = 1'b0;
        entry_d[tail_q].act_target  = '0;
        entry_d[tail_q].mispred     = 1'b0;
        tail_d                      = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
    end
  end

`ifdef BRANCH_UPDATE_STATS_EN
  always_comb begin
    stat_retired_d = stat_retired_q;
    stat_mispred_d = stat_mispred_q;
    if (retire_fire && (stat_retired_q != '1)) stat_retired_d = stat_retired_q + 32'd1;
    if (squash && (stat_mispred_q != '1))      stat_mispred_d = stat_mispred_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_INVALID;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      update_en_q      <= 1'b0;
      update_pht_q     <= '0;
      update_bht_q     <= '0;
      branch_en_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
`ifdef BRANCH_UPDATE_STATS_EN
      stat_retired_q   <= '0;
      stat_mispred_q   <= '0;
`endif
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      update_en_q      <= update_en_d;
      update_pht_q     <= update_pht_d;
      update_bht_q     <= update_bht_d;
      branch_en_q      <= branch_en_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
`ifdef BRANCH_UPDATE_STATS_EN
      stat_retired_q   <= stat_retired_d;
      stat_mispred_q   <= stat_mispred_d;
`endif
    end
  end

  // Payload needs no reset: a slot is only read once its state says it was written.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign bus.alloc_ready      = alloc_ready;
  assign bus.alloc_tag        = tail_q;
  assign bus.update_en        = update_en_q;
  assign bus.update_PHT_index = update_pht_q;
  assign bus.update_BHT_index = update_bht_q;
  assign bus.branch_en        = branch_en_q;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
`ifdef BRANCH_UPDATE_STATS_EN
  assign bus.stat_retired     = stat_retired_q;
  assign bus.stat_mispred     = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: expected predictor updates go into a scoreboard
// queue, a negedge monitor pops and compares them including the cycle they must appear.
module tb_branch_update_queue;
  import branch_update_queue_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  branch_update_queue_if bus();

  branch_update_queue dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [PHT_IDX_W-1:0] pht;
    logic [BHT_IDX_W-1:0] bht;
    logic                 br;
    logic                 redir;
    logic [PC_W-1:0]      rpc;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clearInputs();
    bus.alloc_valid       = 1'b0;
    bus.alloc_pc          = '0;
    bus.alloc_pht_index   = '0;
    bus.alloc_bht_index   = '0;
    bus.alloc_pred_taken  = 1'b0;
    bus.alloc_pred_target = '0;
    bus.resolve_valid     = 1'b0;
    bus.resolve_tag       = '0;
    bus.resolve_taken     = 1'b0;
    bus.resolve_target    = '0;
    bus.retire_valid      = 1'b0;
  endtask

  task automatic setAlloc(input logic [PC_W-1:0] pc, input logic [PHT_IDX_W-1:0] pht,
                          input logic [BHT_IDX_W-1:0] bht, input logic pt,
                          input logic [PC_W-1:0] tgt);
    bus.alloc_valid       = 1'b1;
    bus.alloc_pc          = pc;
    bus.alloc_pht_index   = pht;
    bus.alloc_bht_index   = bht;
    bus.alloc_pred_taken  = pt;
    bus.alloc_pred_target = tgt;
  endtask

  task automatic setResolve(input logic [PTR_W-1:0] tag, input logic taken,
                            input logic [PC_W-1:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_tag    = tag;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
  endtask

  // Update is registered: it must be seen one cycle after the edge that samples this retire.
  task automatic expectUpdate(input logic [PHT_IDX_W-1:0] pht, input logic [BHT_IDX_W-1:0] bht,
                              input logic br, input logic redir, input logic [PC_W-1:0] rpc);
    exp_t e;
    e.pht = pht; e.bht = bht; e.br = br; e.redir = redir; e.rpc = rpc; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.update_en === 1'b1 || bus.redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_update: got update_en=%0b redirect_valid=%0b pht=0x%0h, expected none",
                 bus.update_en, bus.redirect_valid, bus.update_PHT_index);
      end else begin
        e = exp_q.pop_front();
        checkOutput("update_cycle", cyc, e.cyc);
        checkOutput("update_en", {31'd0, bus.update_en}, 32'd1);
        checkOutput("update_PHT_index", {25'd0, bus.update_PHT_index}, {25'd0, e.pht});
        checkOutput("update_BHT_index", {28'd0, bus.update_BHT_index}, {28'd0, e.bht});
        checkOutput("branch_en", {31'd0, bus.branch_en}, {31'd0, e.br});
        checkOutput("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.redir});
        checkOutput("redirect_pc", bus.redirect_pc, e.rpc);
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      e = exp_q.pop_front();
      check_cnt++;
      $display("[TB] FAIL missing_update: got no update_en, expected pht=0x%0h by cycle %0d",
               e.pht, e.cyc);
    end
  end

  initial begin
    clearInputs();
    resetn = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
    checkOutput("reset_alloc_tag", {29'd0, bus.alloc_tag}, 32'd0);
    checkOutput("reset_update_en", {31'd0, bus.update_en}, 32'd0);
    checkOutput("reset_branch_en", {31'd0, bus.branch_en}, 32'd0);
    checkOutput("reset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("reset_redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("reset_update_PHT_index", {25'd0, bus.update_PHT_index}, 32'd0);
    resetn = 1'b1;
    applyStimulus();

    // Correctly predicted taken branch
    setAlloc(32'h100, 7'h11, 4'h3, 1'b1, 32'h200); applyStimulus();
    checkOutput("t1_alloc_tag", {29'd0, bus.alloc_tag}, 32'd1);
    setResolve(3'd0, 1'b1, 32'h200); applyStimulus();
    bus.retire_valid = 1'b1; expectUpdate(7'h11, 4'h3, 1'b1, 1'b0, 32'h0); applyStimulus();
    applyStimulus();

    // Predicted taken, actually not taken: redirect to pc+4
    setAlloc(32'h104, 7'h22, 4'h5, 1'b1, 32'h300); applyStimulus();
    setResolve(3'd1, 1'b0, 32'h0); applyStimulus();
    bus.retire_valid = 1'b1; expectUpdate(7'h22, 4'h5, 1'b0, 1'b1, 32'h108); applyStimulus();
    applyStimulus();
    checkOutput("t2_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
    checkOutput("t2_alloc_tag", {29'd0, bus.alloc_tag}, 32'd2);

    // Fill from tag 2 with wrap, then full-queue behaviour
    for (int i = 0; i < 8; i++) begin
      setAlloc(32'h400 + 32'(4 * i), 7'(i), 4'(i), 1'b0, 32'h0); applyStimulus();
      if (i == 5) checkOutput("t3_tail_wrap", {29'd0, bus.alloc_tag}, 32'd0);
    end
    checkOutput("t3_full_ready", {31'd0, bus.alloc_ready}, 32'd0);
    checkOutput("t3_full_tag", {29'd0, bus.alloc_tag}, 32'd2);
    setAlloc(32'h4F0, 7'h7F, 4'hF, 1'b0, 32'h0); applyStimulus();
    checkOutput("t3_ninth_refused", {29'd0, bus.alloc_tag}, 32'd2);
    setResolve(3'd2, 1'b0, 32'h0); applyStimulus();
    bus.retire_valid = 1'b1; setAlloc(32'h4F4, 7'h7E, 4'hE, 1'b0, 32'h0);
    expectUpdate(7'd0, 4'd0, 1'b0, 1'b0, 32'h108); applyStimulus();
    checkOutput("t3_full_retire_alloc_tag", {29'd0, bus.alloc_tag}, 32'd2);
    checkOutput("t3_full_retire_ready", {31'd0, bus.alloc_ready}, 32'd1);
    setResolve(3'd3, 1'b0, 32'h0); applyStimulus();
    bus.retire_valid = 1'b1; setAlloc(32'h480, 7'd8, 4'd8, 1'b0, 32'h0);
    expectUpdate(7'd1, 4'd1, 1'b0, 1'b0, 32'h108); applyStimulus();
    checkOutput("t3_retire_alloc_tag", {29'd0, bus.alloc_tag}, 32'd3);
    checkOutput("t3_retire_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
    setAlloc(32'h484, 7'd9, 4'd9, 1'b0, 32'h0); applyStimulus();
    checkOutput("t3_refill_ready", {31'd0, bus.alloc_ready}, 32'd0);
    checkOutput("t3_refill_tag", {29'd0, bus.alloc_tag}, 32'd4);

    // Reset with resolved entries at the head discards them silently
    for (int t = 4; t < 8; t++) begin
      setResolve(3'(t), 1'b0, 32'h0); applyStimulus();
    end
    resetn = 1'b0; bus.retire_valid = 1'b1; applyStimulus();
    resetn = 1'b0; applyStimulus();
    resetn = 1'b1;
    checkOutput("t6_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
    checkOutput("t6_alloc_tag", {29'd0, bus.alloc_tag}, 32'd0);
    checkOutput("t6_update_en", {31'd0, bus.update_en}, 32'd0);
    bus.retire_valid = 1'b1; applyStimulus();
    applyStimulus();
    checkOutput("t6_empty_retire", {31'd0, bus.update_en}, 32'd0);

    // Out-of-order resolve, in-order retire
    setAlloc(32'h500, 7'h30, 4'hA, 1'b1, 32'h600); applyStimulus();
    setAlloc(32'h504, 7'h31, 4'hB, 1'b1, 32'h610); applyStimulus();
    setAlloc(32'h508, 7'h32, 4'hC, 1'b1, 32'h620); applyStimulus();
    checkOutput("t4_alloc_tag", {29'd0, bus.alloc_tag}, 32'd3);
    setResolve(3'd2, 1'b1, 32'h620); bus.retire_valid = 1'b1; applyStimulus();
    setResolve(3'd0, 1'b1, 32'h600); bus.retire_valid = 1'b1; applyStimulus();
    setResolve(3'd1, 1'b1, 32'h610); bus.retire_valid = 1'b1;
    expectUpdate(7'h30, 4'hA, 1'b1, 1'b0, 32'h0); applyStimulus();
    bus.retire_valid = 1'b1; expectUpdate(7'h31, 4'hB, 1'b1, 1'b0, 32'h0); applyStimulus();
    bus.retire_valid = 1'b1; expectUpdate(7'h32, 4'hC, 1'b1, 1'b0, 32'h0); applyStimulus();
    applyStimulus();

    // Mispredict at head with younger pending entries and a concurrent alloc
    setAlloc(32'h700, 7'h40, 4'hD, 1'b0, 32'h0); applyStimulus();
    setAlloc(32'h704, 7'h41, 4'h4, 1'b0, 32'h0); applyStimulus();
    setAlloc(32'h708, 7'h42, 4'h5, 1'b0, 32'h0); applyStimulus();
    setAlloc(32'h70C, 7'h43, 4'h6, 1'b0, 32'h0); applyStimulus();
    checkOutput("t5_alloc_tag", {29'd0, bus.alloc_tag}, 32'd7);
    setResolve(3'd3, 1'b1, 32'h7F0); applyStimulus();
    bus.retire_valid = 1'b1; setAlloc(32'h710, 7'h44, 4'h1, 1'b0, 32'h0);
    #1;
    checkOutput("t5_alloc_tag_shown", {29'd0, bus.alloc_tag}, 32'd7);
    expectUpdate(7'h40, 4'hD, 1'b1, 1'b1, 32'h7F0); applyStimulus();
    checkOutput("t5_squash_ready", {31'd0, bus.alloc_ready}, 32'd1);
    checkOutput("t5_squash_tag", {29'd0, bus.alloc_tag}, 32'd7);
    setResolve(3'd4, 1'b1, 32'h123); applyStimulus();
    bus.retire_valid = 1'b1; applyStimulus();
    applyStimulus();
    setAlloc(32'h720, 7'h50, 4'h2, 1'b1, 32'h800); applyStimulus();
    setResolve(3'd7, 1'b1, 32'h800); applyStimulus();
    bus.retire_valid = 1'b1; expectUpdate(7'h50, 4'h2, 1'b1, 1'b0, 32'h7F0); applyStimulus();

    repeat (3) applyStimulus();
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
